i2f_arbiter: RTL and testbench

Round-robin scheduler that shares one `converter_i2f` instance between `N_CH` integer sample producers, typically the ADS1292 filter channels. Each requester uses the same STB/ACK handshake as the converter. The arbiter grants one requester, forwards its operand, waits for the float result and returns it to that requester only. It sits between the ADS1292 channel datapaths and the single float converter, so no second converter is needed.

---
 rtl/i2f_arb_pkg.sv | 32 +++
 rtl/i2f_arbiter_rr_pick.sv | 26 ++
 rtl/i2f_arbiter.sv | 109 ++++++++++
 tb/tb_i2f_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2f_arb_pkg.sv
// Shared definitions for the round-robin int-to-float arbiter: state encoding,
// channel limit and the round-robin search used by the grant picker.
package i2f_arb_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_A  = 3'd1,
        ISSUE  = 3'd2,
        WAIT_Z = 3'd3,
        PUT_Z  = 3'd4
    } arb_state_t;

    // Returns {found, index}. Searches from ptr+1 upward with wrap-around; the
    // loop runs downward so the nearest hit after ptr is the one that sticks.
    function automatic logic [3:0] rr_select(input logic [MAX_CH-1:0] req,
                                             input logic [2:0]        ptr,
                                             input int                n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/i2f_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting channel after ptr.
module rr_pick
    import i2f_arb_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int GW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   grant,
    output logic            any
);

    logic [MAX_CH-1:0] req_ext;
    logic [3:0]        pick;

    always_comb begin
        req_ext             = '0;
        req_ext[N_CH-1:0]   = req;
        pick                = rr_select(req_ext, 3'(ptr), N_CH);
    end

    assign any   = pick[3];
    assign grant = GW'(pick[2:0]);

endmodule

// File: rtl/i2f_arbiter.sv
// Shares one int-to-float converter between N_CH requesters; one conversion in
// flight, result returned only to the channel that supplied the operand.
module i2f_arbiter
    import i2f_arb_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int GW   = $clog2(N_CH)
) (
    input  logic               i_CLK,
    input  logic               i_RSTN,
    input  logic [32*N_CH-1:0] i_CH_A,
    input  logic [N_CH-1:0]    i_CH_A_STB,
    output logic [N_CH-1:0]    o_CH_A_ACK,
    output logic [31:0]        o_CH_Z,
    output logic [N_CH-1:0]    o_CH_Z_STB,
    input  logic [N_CH-1:0]    i_CH_Z_ACK,
    output logic [31:0]        o_CONV_A,
    output logic               o_CONV_A_STB,
    input  logic               i_CONV_A_ACK,
    input  logic [31:0]        i_CONV_Z,
    input  logic               i_CONV_Z_STB,
    output logic               o_CONV_Z_ACK,
    output logic               o_CONV_RST,
    output logic [GW-1:0]      o_GRANT,
    output logic               o_BUSY
);

    arb_state_t                state;
    logic [GW-1:0]             ptr;
    logic [GW-1:0]             pick_g;
    logic                      pick_any;
    logic [1:0]                conv_rst_q;
    logic [N_CH-1:0][31:0]     ch_a_arr;

    assign ch_a_arr = i_CH_A;

    rr_pick #(.N_CH(N_CH), .GW(GW)) u_pick (
        .req   (i_CH_A_STB),
        .ptr   (ptr),
        .grant (pick_g),
        .any   (pick_any)
    );

    // Converter reset stays high through the first clock after release.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) conv_rst_q <= 2'b11;
        else         conv_rst_q <= {conv_rst_q[0], 1'b0};
    end

    assign o_CONV_RST = conv_rst_q[1];
    assign o_BUSY     = (state != IDLE);

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state        <= IDLE;
            ptr          <= GW'(N_CH - 1);
            o_GRANT      <= '0;
            o_CH_A_ACK   <= '0;
            o_CH_Z_STB   <= '0;
            o_CH_Z       <= '0;
            o_CONV_A     <= '0;
            o_CONV_A_STB <= 1'b0;
            o_CONV_Z_ACK <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        o_GRANT    <= pick_g;
                        o_CH_A_ACK <= N_CH'(1) << pick_g;
                        state      <= GET_A;
                    end
                end
                // Grant is never revoked: a dropped STB just extends the wait.
                GET_A: begin
                    if (i_CH_A_STB[o_GRANT] && o_CH_A_ACK[o_GRANT]) begin
                        o_CONV_A     <= ch_a_arr[o_GRANT];
                        o_CH_A_ACK   <= '0;
                        o_CONV_A_STB <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (o_CONV_A_STB && i_CONV_A_ACK) begin
                        o_CONV_A_STB <= 1'b0;
                        o_CONV_Z_ACK <= 1'b1;
                        state        <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (i_CONV_Z_STB && o_CONV_Z_ACK) begin
                        o_CH_Z       <= i_CONV_Z;
                        o_CONV_Z_ACK <= 1'b0;
                        o_CH_Z_STB   <= N_CH'(1) << o_GRANT;
                        state        <= PUT_Z;
                    end
                end
                PUT_Z: begin
                    if (o_CH_Z_STB[o_GRANT] && i_CH_Z_ACK[o_GRANT]) begin
                        o_CH_Z_STB <= '0;
                        ptr        <= o_GRANT;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2f_arbiter.sv
// Bench for i2f_arbiter: emulated converter, directed scenarios and a random
// phase, all checked every cycle against a transaction-level arbitration model.
module tb_i2f_arbiter;

    localparam int N  = 3;
    localparam int GW = $clog2(N);

    logic             clk, rst_n;
    logic [32*N-1:0]  ch_a;
    logic [N-1:0]     ch_a_stb, ch_a_ack, ch_z_stb, ch_z_ack;
    logic [31:0]      ch_z, conv_a, conv_z;
    logic             conv_a_stb, conv_a_ack, conv_z_stb, conv_z_ack, conv_rst, busy;
    logic [GW-1:0]    grant;

    i2f_arbiter #(.N_CH(N)) dut (
        .i_CLK(clk), .i_RSTN(rst_n),
        .i_CH_A(ch_a), .i_CH_A_STB(ch_a_stb), .o_CH_A_ACK(ch_a_ack),
        .o_CH_Z(ch_z), .o_CH_Z_STB(ch_z_stb), .i_CH_Z_ACK(ch_z_ack),
        .o_CONV_A(conv_a), .o_CONV_A_STB(conv_a_stb), .i_CONV_A_ACK(conv_a_ack),
        .i_CONV_Z(conv_z), .i_CONV_Z_STB(conv_z_stb), .o_CONV_Z_ACK(conv_z_ack),
        .o_CONV_RST(conv_rst), .o_GRANT(grant), .o_BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit conv_fixed = 1'b0;
    int conv_delay = 0;

    // Model state: arbiter free?, last served channel, current channel.
    bit m_idle = 1'b1;
    int m_last = N - 1;
    int m_cur  = 0;
    int z1_cnt = 0;

    // Random-phase requester bookkeeping.
    bit          gen = 1'b0;
    bit [N-1:0]  prev_ack, waiting, zseen;
    logic [31:0] sent [N];

    function automatic logic [31:0] i2f(input logic [31:0] a);
        logic        s;
        logic [31:0] m, mant, rem, half;
        int          p, e, sh;
        if (a == 32'd0) return 32'd0;
        s = a[31];
        m = s ? (~a + 32'd1) : a;
        p = 31;
        while (!m[p]) p--;
        e = 127 + p;
        if (p <= 23) begin
            mant = m << (23 - p);
        end else begin
            sh   = p - 23;
            mant = m >> sh;
            rem  = m & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
            if (mant[24]) begin mant = mant >> 1; e++; end
        end
        return {s, 8'(e), mant[22:0]};
    endfunction

    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_last = N - 1;
    endtask

    // One clock: snapshot pre-edge values, check post-edge outputs, return at negedge.
    task automatic tick();
        logic [N-1:0] s_stb, s_ack, s_zstb, s_zack;
        logic         s_czs, s_czack, s_rst;
        logic [31:0]  s_cz, s_a, s_chz;
        int           e;
        @(posedge clk);
        s_stb = ch_a_stb; s_ack = ch_a_ack; s_zstb = ch_z_stb; s_zack = ch_z_ack;
        s_czs = conv_z_stb; s_czack = conv_z_ack; s_cz = conv_z; s_chz = ch_z;
        s_a = ch_a[32*m_cur +: 32]; s_rst = rst_n;
        #1;
        if (ch_z_stb[1]) z1_cnt++;
        if (!rst_n || !s_rst) begin
            model_reset();
        end else if (m_idle) begin
            if (|s_stb) begin
                e = rr(s_stb, m_last);
                chk(ch_a_ack == onehot(e) && int'(grant) == e && busy, "rr_grant",
                    {16'(grant), 16'(ch_a_ack)}, {16'(e), 16'(onehot(e))});
                m_cur  = e;
                m_idle = 1'b0;
            end else begin
                chk(!busy && ch_a_ack == '0 && ch_z_stb == '0 && ch_z == s_chz, "idle_quiet",
                    {31'(ch_a_ack), busy}, 32'd0);
            end
        end else begin
            if (s_ack[m_cur] && s_stb[m_cur])
                chk(conv_a == s_a && conv_a_stb, "op_forward", conv_a, s_a);
            if (s_czs && s_czack)
                chk(ch_z == s_cz && ch_z_stb == onehot(m_cur), "res_forward", ch_z, s_cz);
            else
                chk(ch_z == s_chz, "z_hold", ch_z, s_chz);
            if (s_zstb[m_cur] && s_zack[m_cur]) begin
                chk(ch_z_stb == '0 && !busy, "put_done", {31'(ch_z_stb), busy}, 32'd0);
                m_idle = 1'b1;
                m_last = m_cur;
            end else begin
                chk(int'(grant) == m_cur && busy && (ch_a_ack & ~onehot(m_cur)) == '0 &&
                    (ch_z_stb & ~onehot(m_cur)) == '0, "grant_hold",
                    {16'(grant), 8'(ch_a_ack), 8'(ch_z_stb)}, 32'(m_cur));
            end
        end
        @(negedge clk);
    endtask

    // Emulated converter with variable latency on both handshakes.
    initial begin : conv_model
        int          st, dly;
        logic [31:0] op;
        st = 0; dly = 0; op = '0;
        conv_a_ack = 1'b0; conv_z_stb = 1'b0; conv_z = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || conv_rst) begin
                conv_a_ack = 1'b0; conv_z_stb = 1'b0; st = 0;
                continue;
            end
            case (st)
                0: if (conv_a_stb && (conv_fixed || $urandom_range(1) == 0)) begin
                       conv_a_ack = 1'b1; op = conv_a; st = 1;
                   end
                1: begin
                       conv_a_ack = 1'b0;
                       dly = conv_fixed ? conv_delay : int'($urandom_range(3));
                       st = 2;
                   end
                2: if (dly == 0) begin
                       conv_z = i2f(op); conv_z_stb = 1'b1; st = 3;
                   end else dly--;
                default: if (!conv_z_ack) begin conv_z_stb = 1'b0; st = 0; end
            endcase
        end
    end

    task automatic set_a(input int c, input logic [31:0] v);
        ch_a[32*c +: 32] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ch_a = '0; ch_a_stb = '0; ch_z_ack = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk(ch_a_ack == '0 && ch_z_stb == '0 && !conv_a_stb && !conv_z_ack && !busy &&
            conv_a == '0 && ch_z == '0 && grant == '0 && conv_rst, "reset_state",
            {ch_z[15:0], 8'(ch_a_ack), 8'(grant)}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk(conv_rst == 1'b1, "conv_rst_hold", 32'(conv_rst), 32'd1);
        tick();
        chk(conv_rst == 1'b0, "conv_rst_fall", 32'(conv_rst), 32'd0);
    endtask

    task automatic wait_ack(input int c, input bit keep, input string nm);
        int n = 0;
        while (!ch_a_ack[c] && n < 100) begin tick(); n++; end
        chk(ch_a_ack == onehot(c) && int'(grant) == c, {nm, "_ack"},
            {16'(grant), 16'(ch_a_ack)}, {16'(c), 16'(onehot(c))});
        tick();
        if (!keep) ch_a_stb[c] = 1'b0;
    endtask

    task automatic wait_z(input int c, input logic [31:0] exp, input string nm);
        int n = 0;
        while (!ch_z_stb[c] && n < 100) begin tick(); n++; end
        chk(ch_z_stb == onehot(c) && ch_z == exp, {nm, "_result"}, ch_z, exp);
        ch_z_ack[c] = 1'b1;
        tick();
        ch_z_ack[c] = 1'b0;
    endtask

    task automatic auto_step();
        for (int c = 0; c < N; c++) begin
            if (prev_ack[c] && ch_a_stb[c]) begin
                ch_a_stb[c] = 1'b0;
                sent[c]     = ch_a[32*c +: 32];
                waiting[c]  = 1'b1;
            end
            if (ch_z_ack[c]) begin
                ch_z_ack[c] = 1'b0; waiting[c] = 1'b0; zseen[c] = 1'b0;
            end else if (ch_z_stb[c]) begin
                if (!zseen[c]) begin
                    chk(waiting[c] && ch_z == i2f(sent[c]), "rand_result", ch_z, i2f(sent[c]));
                    zseen[c] = 1'b1;
                end
                if ($urandom_range(1) == 0) ch_z_ack[c] = 1'b1;
            end
            if (gen && !ch_a_stb[c] && !waiting[c] && $urandom_range(3) == 0) begin
                case ($urandom_range(7))
                    0: set_a(c, 32'h0000_0000);
                    1: set_a(c, 32'hFFFF_FFFF);
                    2: set_a(c, 32'h7FFF_FFFF);
                    3: set_a(c, 32'h8000_0000);
                    default: set_a(c, $urandom);
                endcase
                ch_a_stb[c] = 1'b1;
            end
            prev_ack[c] = ch_a_ack[c];
        end
    endtask

    initial begin : main
        int          z1_before, n, g;
        int          seq [6] = '{0, 1, 0, 1, 0, 1};
        rst_n = 1'b0; ch_a = '0; ch_a_stb = '0; ch_z_ack = '0;
        @(negedge clk);

        // Single request on ch0.
        do_reset();
        set_a(0, 32'h0000_0001); ch_a_stb[0] = 1'b1;
        z1_before = z1_cnt;
        wait_ack(0, 1'b0, "t1");
        wait_z(0, 32'h3F80_0000, "t1");
        chk(z1_cnt == z1_before, "t1_no_ch1_result", 32'(z1_cnt - z1_before), 32'd0);

        // Simultaneous requests: ch0 first after reset.
        do_reset();
        set_a(0, 32'hFFFF_FFFF); set_a(1, 32'h0000_0000); ch_a_stb[1:0] = 2'b11;
        wait_ack(0, 1'b0, "t2_ch0");
        wait_z(0, 32'hBF80_0000, "t2_ch0");
        wait_ack(1, 1'b0, "t2_ch1");
        wait_z(1, 32'h0000_0000, "t2_ch1");

        // Both channels hold STB for six conversions.
        do_reset();
        set_a(0, 32'd5); set_a(1, -32'sd3); ch_a_stb[1:0] = 2'b11;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (ch_a_ack == '0 && n < 100) begin tick(); n++; end
            g = int'(grant);
            chk(g == seq[i] && ch_a_ack == onehot(seq[i]), "t3_grant_seq", 32'(g), 32'(seq[i]));
            tick();
            wait_z(g, (g == 0) ? 32'h40A0_0000 : 32'hC040_0000, "t3");
        end
        ch_a_stb = '0;

        // ch1 stalls its result ack; ch0 must wait.
        do_reset();
        set_a(1, 32'h7FFF_FFFF); ch_a_stb[1] = 1'b1;
        wait_ack(1, 1'b0, "t4_ch1");
        set_a(0, 32'h0000_0001); ch_a_stb[0] = 1'b1;
        n = 0;
        while (!ch_z_stb[1] && n < 100) begin tick(); n++; end
        for (int i = 0; i < 10; i++) begin
            chk(ch_z_stb == onehot(1) && ch_z == 32'h4F00_0000 && ch_a_ack == '0,
                "t4_stall_hold", ch_z, 32'h4F00_0000);
            tick();
        end
        wait_z(1, 32'h4F00_0000, "t4_ch1");
        wait_ack(0, 1'b0, "t4_ch0");
        wait_z(0, 32'h3F80_0000, "t4_ch0");

        // Reset pulse while waiting on the converter.
        do_reset();
        conv_fixed = 1'b1; conv_delay = 20;
        set_a(0, 32'd5); ch_a_stb[0] = 1'b1;
        wait_ack(0, 1'b0, "t5_pre");
        n = 0;
        while (!conv_z_ack && n < 100) begin tick(); n++; end
        chk(conv_z_ack && busy, "t5_in_wait_z", 32'(conv_z_ack), 32'd1);
        rst_n = 1'b0;
        #1;
        chk(ch_a_ack == '0 && ch_z_stb == '0 && !conv_a_stb && !conv_z_ack && !busy &&
            conv_a == '0 && ch_z == '0 && grant == '0 && conv_rst, "t5_async_reset",
            {conv_a[15:0], 8'(ch_a_ack), 7'(grant), busy}, 32'd0);
        #1;
        rst_n = 1'b1; ch_a_stb = '0; ch_z_ack = '0;
        model_reset();
        tick();
        chk(conv_rst == 1'b1, "t5_conv_rst_hold", 32'(conv_rst), 32'd1);
        tick();
        chk(conv_rst == 1'b0, "t5_conv_rst_fall", 32'(conv_rst), 32'd0);
        conv_fixed = 1'b0;
        set_a(0, 32'h0000_0064); ch_a_stb[0] = 1'b1;
        wait_ack(0, 1'b0, "t5_post");
        wait_z(0, 32'h42C8_0000, "t5_post");

        // Granted channel drops STB in GET_A; grant must stick.
        do_reset();
        set_a(1, 32'd7); ch_a_stb[1] = 1'b1;
        n = 0;
        while (!ch_a_ack[1] && n < 100) begin tick(); n++; end
        ch_a_stb[1] = 1'b0;
        set_a(0, 32'h0000_0010); ch_a_stb[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk(ch_a_ack == onehot(1) && grant == GW'(1) && !conv_a_stb, "t6_grant_kept",
                {16'(grant), 16'(ch_a_ack)}, {16'd1, 16'(onehot(1))});
        end
        set_a(1, 32'h0000_0002); ch_a_stb[1] = 1'b1;
        wait_ack(1, 1'b0, "t6_ch1");
        wait_z(1, 32'h4000_0000, "t6_ch1");
        wait_ack(0, 1'b0, "t6_ch0");
        wait_z(0, 32'h4180_0000, "t6_ch0");

        // Random traffic on all channels.
        do_reset();
        prev_ack = '0; waiting = '0; zseen = '0;
        gen = 1'b1;
        repeat (3000) begin auto_step(); tick(); end
        gen = 1'b0;
        n = 0;
        while ((ch_a_stb != '0 || waiting != '0 || busy) && n < 500) begin
            auto_step(); tick(); n++;
        end
        chk(ch_a_stb == '0 && waiting == '0 && !busy, "rand_drain",
            {8'(ch_a_stb), 8'(waiting), 15'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
